dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller for the MEM stage of the pipelined CPU. It serves MEM-stage loads and stores from a one-word-per-line cache array and resolves misses against a slow data memory through a req/ready handshake. It generates the `stall` that freezes the pipeline registers, including the M/WB hold input, for the duration of every miss. It is the producer of the hold that the pipeline registers consume.

## Interface
- `data_size`, 32: data word width.
- `addr_size`, 32: byte-address width.
- `index_bits`, 4: line-index width, giving 2^index_bits lines. Tag width is `addr_size-index_bits-2`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_read` in 1: MEM-stage load (MemRead).
- `cpu_write` in 1: MEM-stage store (MemWrite).
- `cpu_addr` in `addr_size`: byte address, word aligned; bits [1:0] ignored.
- `cpu_wdata` in `data_size`: store data.
- `cpu_rdata` out `data_size`: load data, feeds the DM read-data pipe input.
- `stall` out 1: 1 = hold every pipeline register (drives the M/WB hold input and the upstream register writes).
- `mem_req` out 1: memory request active.
- `mem_we` out 1: 1 = write-back, 0 = refill read.
- `mem_addr` out `addr_size`: word-aligned memory address.
- `mem_wdata` out `data_size`: victim data for write-back.
- `mem_rdata` in `data_size`: refill data, valid when `mem_ready`=1.
- `mem_ready` in 1: one-cycle completion pulse for the current request.

## Operation
- Address split: tag = `cpu_addr[addr_size-1:index_bits+2]`, index = `cpu_addr[index_bits+1:2]`.
- Per-line state: valid, dirty, tag, data.
- Access = `cpu_read | cpu_write`. If both are asserted, the access is treated as a write.
- Hit = access & valid[index] & (tag[index] == tag).
- FSM states:
  - IDLE: compare.
    - Hit load: `cpu_rdata` = data[index] combinationally.
    - Hit store: data[index] <= `cpu_wdata`, dirty <= 1 at the edge.
    - Miss with victim valid & dirty: go to WRITEBACK. Otherwise go to REFILL.
  - WRITEBACK: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index, 2'b00}, `mem_wdata`=victim data. On `mem_ready`, go to REFILL.
  - REFILL: `mem_req`=1, `mem_we`=0, `mem_addr`={tag, index, 2'b00}. On `mem_ready`: data <= `mem_rdata`, tag <= tag, valid <= 1, dirty <= 0, go to IDLE.
- A store miss completes as a hit in the IDLE cycle after refill. The line becomes dirty then.
- `stall` = (state != IDLE) | (access & !hit). It is combinational, so it rises in the miss cycle itself.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are decoded from the state register and the held CPU inputs. When `mem_req`=0: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `cpu_rdata` = 0 when there is no hit.
- CPU inputs are held stable by the frozen pipeline while `stall`=1. The controller relies on this and does not latch them.
- `mem_ready` while `mem_req`=0 is ignored.

## Timing
- Reset: state=IDLE; all valid and dirty bits = 0; `mem_req`=0. Tag and data arrays are not reset.
- Reset mid-miss abandons the transaction: `mem_req` = 0 from the cycle after the reset edge. A write-back that was in flight is lost.
- Hit: zero stall cycles. Load data is valid in the same cycle; store is written at the same edge.
- Clean miss, with R = REFILL cycles including the `mem_ready` cycle: `stall` high for 1+R cycles, then low in the next IDLE hit cycle.
- Dirty miss, with W = WRITEBACK cycles: `stall` high for 1+W+R cycles.
- No access (both strobes 0): `stall`=0 and no state change.
- `mem_ready` in the same cycle the state is entered is legal, giving a 1-cycle phase.

## Test plan
- **Reset then load:** after reset, load 0x0000_0010 with memory returning 0xDEAD_BEEF after 3 cycles → `stall`=1 for 4 cycles. Refill `mem_addr`=0x10 with `mem_we`=0. Next cycle `cpu_rdata`=0xDEAD_BEEF and `stall`=0.
- **Store hit then load hit:** store 0x1234_5678 to 0x10, then load 0x10 → no stall; `cpu_rdata`=0x1234_5678; no `mem_req`.
- **Conflict on dirty line:** load 0x0000_0050 (same index 4, different tag) while line 4 is dirty → WRITEBACK with `mem_addr`=0x10, `mem_wdata`=0x1234_5678, `mem_we`=1. Then REFILL with `mem_addr`=0x50. `stall` covers 1+W+R cycles.
- **Store miss on clean/invalid line:** store 0xAAAA_5555 to 0x0000_0024 → no write-back; refill 0x24; the store lands in the cycle after refill. A later load of 0x24 returns 0xAAAA_5555 with no stall.
- **Reset during REFILL:** assert `rst` → `mem_req`=0 and `stall`=0 (no access) the next cycle. Re-issuing load 0x10 misses because valid was cleared.
- **Idle bus noise:** a spurious `mem_ready` pulse with no access → no state or array change; `stall` stays 0.

Source files
------------

// File: rtl/dcache_if.sv
// CPU-side and memory-side signals of the MEM-stage data cache.
// The controller takes the slave view; the pipeline/memory environment takes the master view.
interface dcache_if #(
  parameter int data_size = 32,
  parameter int addr_size = 32
);
  logic                 cpu_read;
  logic                 cpu_write;
  logic [addr_size-1:0] cpu_addr;
  logic [data_size-1:0] cpu_wdata;
  logic [data_size-1:0] cpu_rdata;
  logic                 stall;
  logic                 mem_req;
  logic                 mem_we;
  logic [addr_size-1:0] mem_addr;
  logic [data_size-1:0] mem_wdata;
  logic [data_size-1:0] mem_rdata;
  logic                 mem_ready;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Misses stall the pipeline while a victim write-back and/or a line refill run on the memory bus.
module dcache_ctrl #(
  parameter int data_size  = 32,
  parameter int addr_size  = 32,
  parameter int index_bits = 4
) (
  input logic      clk,
  input logic      rst,
  dcache_if.slave  bus
);
  localparam int lines = 1 << index_bits;
  localparam int tag_w = addr_size - index_bits - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic [lines-1:0]       valid, dirty;
  logic [tag_w-1:0]       tag_arr  [lines];
  logic [data_size-1:0]   data_arr [lines];

  logic [index_bits-1:0]  idx;
  logic [tag_w-1:0]       tag;
  logic                   access, hit, store_hit, refill_done;
  logic                   req, we;
  logic [addr_size-1:0]   maddr;
  logic [data_size-1:0]   mwdata;
  logic [1:0]             unused_addr_lo;

  assign idx            = bus.cpu_addr[index_bits+1:2];
  assign tag            = bus.cpu_addr[addr_size-1:index_bits+2];
  assign unused_addr_lo = bus.cpu_addr[1:0];
  assign access         = bus.cpu_read | bus.cpu_write;

  // Lookup only counts in IDLE; during a miss the held address cannot match the line yet.
  assign hit         = (state == IDLE) & access & valid[idx] & (tag_arr[idx] == tag);
  assign store_hit   = hit & bus.cpu_write;
  assign refill_done = (state == REFILL) & bus.mem_ready;

  assign bus.stall     = (state != IDLE) | (access & ~hit);
  assign bus.cpu_rdata = hit ? data_arr[idx] : '0;
  assign bus.mem_req   = req;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = maddr;
  assign bus.mem_wdata = mwdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    we       = 1'b0;
    maddr    = '0;
    mwdata   = '0;
    case (state)
      IDLE: begin
        if (access && !hit)
          state_nx = (valid[idx] && dirty[idx]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        req    = 1'b1;
        we     = 1'b1;
        maddr  = {tag_arr[idx], idx, 2'b00};
        mwdata = data_arr[idx];
        if (bus.mem_ready) state_nx = REFILL;
      end
      REFILL: begin
        req   = 1'b1;
        maddr = {tag, idx, 2'b00};
        if (bus.mem_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line status bits are the only array state cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (refill_done) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (store_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (refill_done) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= bus.mem_rdata;
    end else if (store_hit) begin
      data_arr[idx] <= bus.cpu_wdata;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: transaction-queue cache model checked every cycle,
// plus hand-computed stall counts, bus transactions and load data for each scenario.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_if #(.data_size(32), .addr_size(32)) dif ();
  dcache_ctrl #(.data_size(32), .addr_size(32), .index_bits(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          mv   [16];
  bit          md   [16];
  logic [25:0] mt   [16];
  logic [31:0] mdat [16];
  txn_t        pend [$];   // memory transactions still owed for the current miss
  bit          model_ok = 0;

  function automatic bit m_hit();
    int i;
    i = int'(dif.cpu_addr[5:2]);
    return (pend.size() == 0) && (dif.cpu_read || dif.cpu_write) &&
           mv[i] && (mt[i] == dif.cpu_addr[31:6]);
  endfunction

  always @(posedge clk) begin
    int   i;
    txn_t t;
    i = int'(dif.cpu_addr[5:2]);
    if (rst) begin
      for (int k = 0; k < 16; k++) begin mv[k] = 0; md[k] = 0; end
      pend.delete();
      model_ok = 1;
    end else if (model_ok) begin
      if (pend.size() != 0) begin
        if (dif.mem_ready) begin
          t = pend.pop_front();
          if (!t.we) begin
            mv[i] = 1; md[i] = 0;
            mt[i] = dif.cpu_addr[31:6];
            mdat[i] = dif.mem_rdata;
          end
        end
      end else if (dif.cpu_read || dif.cpu_write) begin
        if (m_hit()) begin
          if (dif.cpu_write) begin mdat[i] = dif.cpu_wdata; md[i] = 1; end
        end else begin
          if (mv[i] && md[i]) pend.push_back('{1'b1, {mt[i], dif.cpu_addr[5:2], 2'b00}, mdat[i]});
          pend.push_back('{1'b0, {dif.cpu_addr[31:2], 2'b00}, 32'h0});
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit hit_e, acc;
    if (model_ok) begin
      hit_e = m_hit();
      acc   = dif.cpu_read || dif.cpu_write;
      chk("stall",     {31'h0, dif.stall}, {31'h0, (pend.size() != 0) || (acc && !hit_e)});
      chk("cpu_rdata", dif.cpu_rdata, hit_e ? mdat[int'(dif.cpu_addr[5:2])] : 32'h0);
      if (pend.size() != 0) begin
        chk("mem_req",   {31'h0, dif.mem_req}, 32'h1);
        chk("mem_we",    {31'h0, dif.mem_we}, {31'h0, pend[0].we});
        chk("mem_addr",  dif.mem_addr, pend[0].addr);
        chk("mem_wdata", dif.mem_wdata, pend[0].wdata);
      end else begin
        chk("mem_req_idle", {dif.mem_req, dif.mem_we, 30'h0}, 32'h0);
        chk("mem_addr_idle", dif.mem_addr | dif.mem_wdata, 32'h0);
      end
    end
  end

  // ---------------- memory responder and bus monitor ----------------
  logic [31:0] bmem [int];
  int   lat = 1;
  bit   noise = 0;
  txn_t obs [$];

  initial begin
    int cnt;
    cnt = 0;
    dif.mem_ready = 1'b0;
    dif.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      dif.mem_ready = noise;
      dif.mem_rdata = 32'h0;
      if (dif.mem_req && !rst) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          dif.mem_ready = 1'b1;
          if (dif.mem_we) bmem[int'(dif.mem_addr)] = dif.mem_wdata;
          else dif.mem_rdata = bmem.exists(int'(dif.mem_addr)) ? bmem[int'(dif.mem_addr)]
                                                               : (dif.mem_addr ^ 32'hC0DE_0000);
        end
      end else cnt = 0;
    end
  end

  always @(negedge clk)
    if (dif.mem_req && dif.mem_ready) obs.push_back('{dif.mem_we, dif.mem_addr, dif.mem_wdata});

  // ---------------- directed stimulus ----------------
  // Called at posedge+1; returns at posedge+1 after the completing (non-stall) cycle.
  task automatic cpu_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stalls, output logic [31:0] rdata);
    obs.delete();
    dif.cpu_read = rd; dif.cpu_write = wr; dif.cpu_addr = addr; dif.cpu_wdata = wdata;
    stalls = 0;
    #1;
    while (dif.stall && stalls < 200) begin
      stalls++;
      @(posedge clk); #2;
    end
    if (stalls >= 200) chk("stall_timeout", 32'(stalls), 32'h0);
    rdata = dif.cpu_rdata;
    @(posedge clk); #1;
    dif.cpu_read = 0; dif.cpu_write = 0;
  endtask

  initial begin
    int          st;
    logic [31:0] rd;
    rst = 1'b1;
    dif.cpu_read = 0; dif.cpu_write = 0; dif.cpu_addr = '0; dif.cpu_wdata = '0;
    bmem[32'h10] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_stall",   {31'h0, dif.stall}, 32'h0);
    chk("reset_mem_req", {31'h0, dif.mem_req}, 32'h0);
    chk("reset_rdata",   dif.cpu_rdata, 32'h0);
    @(posedge clk); #1;

    // Cold load miss, refill in 3 cycles
    lat = 3;
    cpu_op(1, 0, 32'h10, 0, st, rd);
    chk("load_miss_stalls", 32'(st), 32'd4);
    chk("load_miss_rdata",  rd, 32'hDEAD_BEEF);
    chk("load_miss_ntxn",   32'(obs.size()), 32'd1);
    if (obs.size() > 0) begin
      chk("load_miss_addr", obs[0].addr, 32'h10);
      chk("load_miss_we",   {31'h0, obs[0].we}, 32'h0);
    end

    // Store hit then load hit
    cpu_op(0, 1, 32'h10, 32'h1234_5678, st, rd);
    chk("store_hit_stalls", 32'(st), 32'd0);
    chk("store_hit_ntxn",   32'(obs.size()), 32'd0);
    cpu_op(1, 0, 32'h10, 0, st, rd);
    chk("load_hit_stalls",  32'(st), 32'd0);
    chk("load_hit_rdata",   rd, 32'h1234_5678);

    // Dirty conflict: write-back of 0x10 then refill of 0x50, 2 cycles each
    lat = 2;
    cpu_op(1, 0, 32'h50, 0, st, rd);
    chk("conflict_stalls", 32'(st), 32'd5);
    chk("conflict_ntxn",   32'(obs.size()), 32'd2);
    if (obs.size() > 1) begin
      chk("wb_we",    {31'h0, obs[0].we}, 32'h1);
      chk("wb_addr",  obs[0].addr, 32'h10);
      chk("wb_wdata", obs[0].wdata, 32'h1234_5678);
      chk("rf_addr",  obs[1].addr, 32'h50);
      chk("rf_we",    {31'h0, obs[1].we}, 32'h0);
    end
    chk("conflict_rdata", rd, 32'hC0DE_0050);

    // Store miss on an invalid line, 1-cycle refill
    lat = 1;
    cpu_op(0, 1, 32'h24, 32'hAAAA_5555, st, rd);
    chk("store_miss_stalls", 32'(st), 32'd2);
    chk("store_miss_ntxn",   32'(obs.size()), 32'd1);
    if (obs.size() > 0) chk("store_miss_addr", obs[0].addr, 32'h24);
    cpu_op(1, 0, 32'h24, 0, st, rd);
    chk("store_miss_reload_stalls", 32'(st), 32'd0);
    chk("store_miss_reload_rdata",  rd, 32'hAAAA_5555);

    // Read and write together behave as a store
    cpu_op(1, 1, 32'h24, 32'h0BAD_F00D, st, rd);
    chk("rw_stalls", 32'(st), 32'd0);
    cpu_op(1, 0, 32'h24, 0, st, rd);
    chk("rw_rdata", rd, 32'h0BAD_F00D);

    // Reset during refill of 0x10 (line 4 holds clean 0x50)
    lat = 50;
    dif.cpu_read = 1; dif.cpu_addr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_mem_req", {31'h0, dif.mem_req}, 32'h1);
    rst = 1'b1; dif.cpu_read = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_reset_mem_req", {31'h0, dif.mem_req}, 32'h0);
    chk("post_reset_stall",   {31'h0, dif.stall}, 32'h0);
    @(posedge clk); #1;
    lat = 2;
    cpu_op(1, 0, 32'h10, 0, st, rd);
    chk("reissue_stalls", 32'(st), 32'd3);
    chk("reissue_rdata",  rd, 32'h1234_5678);

    // Spurious mem_ready with no access
    noise = 1;
    @(posedge clk); #2;
    chk("noise_stall",   {31'h0, dif.stall}, 32'h0);
    chk("noise_mem_req", {31'h0, dif.mem_req}, 32'h0);
    @(posedge clk); #1;
    noise = 0;
    @(posedge clk); #1;
    cpu_op(1, 0, 32'h10, 0, st, rd);
    chk("after_noise_stalls", 32'(st), 32'd0);
    chk("after_noise_rdata",  rd, 32'h1234_5678);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end
endmodule
